// File: rtl/pa_risc_pkg.sv
// Shared definitions for the pa_risc core: opcodes, ALU ext codes, COMB conditions,
// pipeline register layouts and the combinational ALU.
package pa_risc_pkg;

  localparam logic [5:0] OP_ALU  = 6'h02;
  localparam logic [5:0] OP_LDO  = 6'h0D;
  localparam logic [5:0] OP_LDW  = 6'h12;
  localparam logic [5:0] OP_STW  = 6'h1A;
  localparam logic [5:0] OP_COMB = 6'h20;
  localparam logic [5:0] OP_BL   = 6'h3A;

  localparam logic [5:0] EXT_ADD = 6'h18;
  localparam logic [5:0] EXT_SUB = 6'h10;
  localparam logic [5:0] EXT_AND = 6'h08;
  localparam logic [5:0] EXT_OR  = 6'h09;
  localparam logic [5:0] EXT_XOR = 6'h0A;

  localparam logic [2:0] CND_NEVER = 3'd0;
  localparam logic [2:0] CND_EQ    = 3'd1;
  localparam logic [2:0] CND_LT    = 3'd2;

  // vld_pipe[0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
  localparam int STAGES = 3;

  typedef enum logic [1:0] {EXK_ALU, EXK_ADDI, EXK_PASS} ex_kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    ex_kind_e    kind;
    logic [5:0]  ext;
    logic        wr;
    logic        ld;
    logic        st;
    logic [4:0]  dst;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        wr;
    logic        ld;
    logic        st;
    logic [4:0]  dst;
    logic [31:0] res;
    logic [31:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] data;
  } memwb_t;

  function automatic logic ext_valid(input logic [5:0] ext);
    return (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_AND) ||
           (ext == EXT_OR)  || (ext == EXT_XOR);
  endfunction

  function automatic logic [31:0] alu(input logic [5:0] ext, input logic [31:0] a,
                                      input logic [31:0] b);
    case (ext)
      EXT_ADD: return a + b;
      EXT_SUB: return a - b;
      EXT_AND: return a & b;
      EXT_OR:  return a | b;
      EXT_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pa_risc_regfile.sv
// 32x32 general register file; GR0 reads zero, WB write is visible to a same-cycle read.
module pa_risc_regfile (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] reg_file [0:31];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (we && wa != 5'd0) begin
      reg_file[wa] <= wd;
    end
  end

  assign rd_a = (ra_a == 5'd0) ? '0 : (we && wa == ra_a) ? wd : reg_file[ra_a];
  assign rd_b = (ra_b == 5'd0) ? '0 : (we && wa == ra_b) ? wd : reg_file[ra_b];

endmodule

// File: rtl/pa_risc.sv
// Five-stage PA-RISC subset core with PC front/back queue (one delay slot),
// branch resolution in ID and interlock-only hazard handling.
module pa_risc
  import pa_risc_pkg::*;
#(
  parameter string IMEM_FILE = "program.hex",
  parameter string DMEM_FILE = "data.hex",
  parameter int    MEM_BYTES = 256
) (
  input logic clk,
  input logic reset
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] imem [0:MEM_BYTES-1];
  logic [7:0] dmem [0:MEM_BYTES-1];

  logic [31:0]     pc_front_q, pc_front_d, pc_back_q, pc_back_d;
  ifid_t           ifid_q, ifid_d;
  idex_t           idex_q, idex_d;
  exmem_t          exmem_q, exmem_d;
  memwb_t          memwb_q, memwb_d;
  logic [STAGES:0] vld_pipe_q, vld_pipe_d;

  logic [31:0] PCFrontOut;
  assign PCFrontOut = pc_front_q;

  // Fetch: big-endian word at PC front, wrapped into the ROM
  logic [AW-1:0] fa0, fa1, fa2, fa3;
  logic [31:0]   if_instr;
  assign fa0 = {pc_front_q[AW-1:2], 2'b00};
  assign fa1 = fa0 + AW'(1);
  assign fa2 = fa0 + AW'(2);
  assign fa3 = fa0 + AW'(3);
  assign if_instr = {imem[fa0], imem[fa1], imem[fa2], imem[fa3]};

  // Decode
  logic [31:0] instr, rd_a, rd_b, br_tgt;
  logic [5:0]  op;
  logic [4:0]  ra, rb;
  logic        use_a, use_b, br_take, stall, taken;
  idex_t       dec;

  assign instr = ifid_q.instr;
  assign op    = instr[31:26];
  assign ra    = instr[25:21];
  assign rb    = instr[20:16];

  pa_risc_regfile RF (
    .gclk  (clk),
    .grst_n(reset),
    .ra_a  (ra),
    .ra_b  (rb),
    .rd_a  (rd_a),
    .rd_b  (rd_b),
    .we    (vld_pipe_q[3] && memwb_q.wr),
    .wa    (memwb_q.dst),
    .wd    (memwb_q.data)
  );

  always_comb begin
    use_a    = 1'b0;
    use_b    = 1'b0;
    br_take  = 1'b0;
    br_tgt   = ifid_q.pc + 32'd8 + {{19{instr[12]}}, instr[12:2], 2'b00};
    dec      = '0;
    dec.kind = EXK_ADDI;
    dec.ext  = instr[11:6];
    dec.opa  = rd_a;
    dec.opb  = rd_b;
    dec.imm  = {{18{instr[13]}}, instr[13:0]};
    case (op)
      OP_ALU: begin
        use_a = 1'b1; use_b = 1'b1;
        dec.kind = EXK_ALU;
        dec.dst  = instr[4:0];
        dec.wr   = ext_valid(instr[11:6]);
      end
      OP_LDO: begin use_a = 1'b1; dec.dst = rb; dec.wr = 1'b1; end
      OP_LDW: begin use_a = 1'b1; dec.dst = rb; dec.wr = 1'b1; dec.ld = 1'b1; end
      OP_STW: begin use_a = 1'b1; use_b = 1'b1; dec.st = 1'b1; end
      OP_COMB: begin
        use_a = 1'b1; use_b = 1'b1;
        case (instr[15:13])
          CND_EQ:  br_take = (rd_a == rd_b);
          CND_LT:  br_take = ($signed(rd_a) < $signed(rd_b));
          default: br_take = 1'b0;
        endcase
      end
      OP_BL: begin
        dec.kind = EXK_PASS;
        dec.dst  = ra;
        dec.wr   = 1'b1;
        dec.opa  = ifid_q.pc + 32'd8;
        br_take  = 1'b1;
        br_tgt   = ifid_q.pc + 32'd8 + {{9{instr[20]}}, instr[20:0], 2'b00};
      end
      default: ;
    endcase
    if (dec.dst == 5'd0) dec.wr = 1'b0;
  end

  // No forwarding: wait until producers leave EX and MEM; WB is covered by the RF bypass
  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) &&
           ((vld_pipe_q[1] && idex_q.wr && idex_q.dst == r) ||
            (vld_pipe_q[2] && exmem_q.wr && exmem_q.dst == r));
  endfunction

  assign stall = vld_pipe_q[0] && ((use_a && busy(ra)) || (use_b && busy(rb)));
  assign taken = vld_pipe_q[0] && !stall && br_take;

  // Execute
  logic [31:0] ex_res;
  always_comb begin
    case (idex_q.kind)
      EXK_ALU:  ex_res = alu(idex_q.ext, idex_q.opa, idex_q.opb);
      EXK_PASS: ex_res = idex_q.opa;
      default:  ex_res = idex_q.opa + idex_q.imm;
    endcase
  end

  // Memory
  logic [AW-1:0] ma0, ma1, ma2, ma3;
  logic [31:0]   ld_data;
  assign ma0 = {exmem_q.res[AW-1:2], 2'b00};
  assign ma1 = ma0 + AW'(1);
  assign ma2 = ma0 + AW'(2);
  assign ma3 = ma0 + AW'(3);
  assign ld_data = {dmem[ma0], dmem[ma1], dmem[ma2], dmem[ma3]};

  always @(posedge clk) begin
    if (vld_pipe_q[2] && exmem_q.st) begin
      dmem[ma0] <= exmem_q.sdata[31:24];
      dmem[ma1] <= exmem_q.sdata[23:16];
      dmem[ma2] <= exmem_q.sdata[15:8];
      dmem[ma3] <= exmem_q.sdata[7:0];
    end
  end

  always_comb begin
    pc_front_d = pc_front_q;
    pc_back_d  = pc_back_q;
    ifid_d     = ifid_q;
    vld_pipe_d = {vld_pipe_q[2:1], vld_pipe_q[0] && !stall, vld_pipe_q[0]};
    if (!stall) begin
      ifid_d.pc     = pc_front_q;
      ifid_d.instr  = if_instr;
      vld_pipe_d[0] = 1'b1;
      pc_front_d    = taken ? br_tgt : pc_back_q;
      pc_back_d     = taken ? br_tgt + 32'd4 : pc_back_q + 32'd4;
    end
    idex_d        = dec;
    exmem_d.wr    = idex_q.wr;
    exmem_d.ld    = idex_q.ld;
    exmem_d.st    = idex_q.st;
    exmem_d.dst   = idex_q.dst;
    exmem_d.res   = ex_res;
    exmem_d.sdata = idex_q.opb;
    memwb_d.wr    = exmem_q.wr;
    memwb_d.dst   = exmem_q.dst;
    memwb_d.data  = exmem_q.ld ? ld_data : exmem_q.res;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_front_q <= 32'd0;
      pc_back_q  <= 32'd4;
      ifid_q     <= '0;
      idex_q     <= '0;
      exmem_q    <= '0;
      memwb_q    <= '0;
      vld_pipe_q <= '0;
    end else begin
      pc_front_q <= pc_front_d;
      pc_back_q  <= pc_back_d;
      ifid_q     <= ifid_d;
      idex_q     <= idex_d;
      exmem_q    <= exmem_d;
      memwb_q    <= memwb_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

endmodule

// File: tb/tb_pa_risc.sv
// Directed-program bench for pa_risc: loads small programs into the ROM and checks
// PC front sequences and architectural register / memory state.
module tb_pa_risc;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [31:0] prog [$];

  pa_risc #(.IMEM_FILE(""), .DMEM_FILE(""), .MEM_BYTES(256)) dut (
    .clk  (clk),
    .reset(reset)
  );

  always #2 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_mem(input logic [5:0] opc, input logic [13:0] imm,
                                        input logic [4:0] a, input logic [4:0] b);
    return {opc, a, b, 2'b00, imm};
  endfunction
  function automatic logic [31:0] f_ldo(input logic [13:0] imm, input logic [4:0] a, input logic [4:0] b);
    return f_mem(6'h0D, imm, a, b);
  endfunction
  function automatic logic [31:0] f_ldw(input logic [13:0] imm, input logic [4:0] a, input logic [4:0] b);
    return f_mem(6'h12, imm, a, b);
  endfunction
  function automatic logic [31:0] f_stw(input logic [13:0] imm, input logic [4:0] a, input logic [4:0] b);
    return f_mem(6'h1A, imm, a, b);
  endfunction
  function automatic logic [31:0] f_alu(input logic [4:0] a, input logic [4:0] b,
                                        input logic [5:0] ext, input logic [4:0] t);
    return {6'h02, a, b, 4'h0, ext, 1'b0, t};
  endfunction
  function automatic logic [31:0] f_comb(input logic [2:0] cnd, input logic [4:0] a,
                                         input logic [4:0] b, input logic [10:0] disp);
    return {6'h20, a, b, cnd, disp, 2'b00};
  endfunction
  function automatic logic [31:0] f_bl(input logic [4:0] t, input logic [20:0] disp);
    return {6'h3A, t, disp};
  endfunction

  function automatic logic [31:0] gr(input int i);
    return dut.RF.reg_file[i];
  endfunction

  function automatic logic [31:0] dword(input int a);
    return {dut.dmem[a], dut.dmem[a+1], dut.dmem[a+2], dut.dmem[a+3]};
  endfunction

  task automatic put_prog();
    for (int i = 0; i < 256; i++) dut.imem[i] = 8'h00;
    foreach (prog[i]) begin
      dut.imem[4*i]   = prog[i][31:24];
      dut.imem[4*i+1] = prog[i][23:16];
      dut.imem[4*i+2] = prog[i][15:8];
      dut.imem[4*i+3] = prog[i][7:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    put_prog();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pc2 [7] = '{4, 8, 12, 12, 12, 16, 20};
    int pc5 [7] = '{4, 8, 12, 16, 20, 32, 36};
    int pc5n[6] = '{4, 8, 12, 16, 20, 24};

    // reset with an all-NOP program
    prog.delete();
    put_prog();
    @(posedge clk);
    #1;
    chk("rst_pc", dut.PCFrontOut, 32'd0);
    for (int i = 1; i <= 5; i++) chk($sformatf("rst_gr%0d", i), gr(i), 32'd0);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("nop_pc", dut.PCFrontOut, 32'(4 * k));
    end

    // LDO/LDO/ADD/SUB with interlock
    prog = {f_ldo(14'd5, 5'd0, 5'd1), f_ldo(14'd7, 5'd0, 5'd2),
            f_alu(5'd1, 5'd2, 6'h18, 5'd3), f_alu(5'd1, 5'd2, 6'h10, 5'd5)};
    restart();
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("stall_pc%0d", k + 1), dut.PCFrontOut, 32'(pc2[k]));
      if (k == 3) chk("lat_gr1_early", gr(1), 32'd0);
      if (k == 4) begin
        chk("lat_gr1", gr(1), 32'd5);
        chk("lat_gr2_early", gr(2), 32'd0);
      end
      if (k == 5) chk("lat_gr2", gr(2), 32'd7);
    end
    repeat (6) tick();
    chk("add_gr3", gr(3), 32'd12);
    chk("sub_gr5", gr(5), 32'hFFFF_FFFE);

    // logic ops, undefined ext, negative immediate
    prog = {f_ldo(14'h0F0F, 5'd0, 5'd1), f_ldo(14'h00FF, 5'd0, 5'd2), 32'h0, 32'h0,
            f_alu(5'd1, 5'd2, 6'h08, 5'd3), f_alu(5'd1, 5'd2, 6'h09, 5'd4),
            f_alu(5'd1, 5'd2, 6'h0A, 5'd5), f_alu(5'd1, 5'd2, 6'h3F, 5'd6),
            f_ldo(14'h3FFF, 5'd0, 5'd7)};
    restart();
    repeat (20) tick();
    chk("and_gr3", gr(3), 32'h0000_000F);
    chk("or_gr4",  gr(4), 32'h0000_0FFF);
    chk("xor_gr5", gr(5), 32'h0000_0FF0);
    chk("badext_gr6", gr(6), 32'd0);
    chk("ldo_neg_gr7", gr(7), 32'hFFFF_FFFF);

    // store/load, load-use interlock, address wrap and low-bit masking
    prog = {f_ldo(14'd5, 5'd0, 5'd1), f_ldo(14'd7, 5'd0, 5'd2),
            f_alu(5'd1, 5'd2, 6'h18, 5'd3), f_stw(14'd8, 5'd0, 5'd3),
            f_ldw(14'd8, 5'd0, 5'd5), f_alu(5'd5, 5'd5, 6'h18, 5'd2),
            f_stw(14'h10C, 5'd0, 5'd3), f_ldw(14'd14, 5'd0, 5'd6)};
    restart();
    repeat (30) tick();
    chk("ldw_gr5", gr(5), 32'd12);
    chk("lduse_gr2", gr(2), 32'd24);
    chk("dmem_w8", dword(8), 32'd12);
    chk("wrap_gr6", gr(6), 32'd12);
    chk("dmem_w12", dword(12), 32'd12);

    // COMB equal taken at PC 16
    prog = {f_ldo(14'd3, 5'd0, 5'd1), f_ldo(14'd3, 5'd0, 5'd2), 32'h0, 32'h0,
            f_comb(3'd1, 5'd1, 5'd2, 11'd2),
            f_ldo(14'd1, 5'd0, 5'd10), f_ldo(14'd1, 5'd0, 5'd11),
            f_ldo(14'd1, 5'd0, 5'd12), f_ldo(14'd1, 5'd0, 5'd13)};
    restart();
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("comb_pc%0d", k + 1), dut.PCFrontOut, 32'(pc5[k]));
    end
    repeat (20) tick();
    chk("comb_slot", gr(10), 32'd1);
    chk("comb_skip24", gr(11), 32'd0);
    chk("comb_skip28", gr(12), 32'd0);
    chk("comb_tgt", gr(13), 32'd1);

    // signed COMB: 3<-1 falls through, then -1<3 taken
    prog = {f_ldo(14'd3, 5'd0, 5'd1), f_ldo(14'h3FFF, 5'd0, 5'd4), 32'h0, 32'h0,
            f_comb(3'd2, 5'd1, 5'd4, 11'd2),
            f_ldo(14'd1, 5'd0, 5'd10), f_ldo(14'd1, 5'd0, 5'd11),
            f_ldo(14'd1, 5'd0, 5'd12), f_ldo(14'd1, 5'd0, 5'd13),
            f_comb(3'd2, 5'd4, 5'd1, 11'd2),
            f_ldo(14'd1, 5'd0, 5'd14), f_ldo(14'd1, 5'd0, 5'd15),
            f_ldo(14'd1, 5'd0, 5'd16), f_ldo(14'd1, 5'd0, 5'd17)};
    restart();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("nt_pc%0d", k + 1), dut.PCFrontOut, 32'(pc5n[k]));
    end
    repeat (24) tick();
    chk("nt_fall24", gr(11), 32'd1);
    chk("nt_fall28", gr(12), 32'd1);
    chk("lt_slot", gr(14), 32'd1);
    chk("lt_skip", gr(15) | gr(16), 32'd0);
    chk("lt_tgt", gr(17), 32'd1);

    // BL at 0, disp 1, link into r2
    prog = {f_bl(5'd2, 21'd1), f_ldo(14'd1, 5'd0, 5'd3),
            f_ldo(14'd1, 5'd0, 5'd4), f_ldo(14'd1, 5'd0, 5'd5)};
    restart();
    tick(); chk("bl_pc1", dut.PCFrontOut, 32'd4);
    tick(); chk("bl_pc2", dut.PCFrontOut, 32'd12);
    repeat (10) tick();
    chk("bl_link", gr(2), 32'd8);
    chk("bl_slot", gr(3), 32'd1);
    chk("bl_skip", gr(4), 32'd0);
    chk("bl_tgt", gr(5), 32'd1);

    // reset mid-program, with a store sitting in MEM
    prog = {f_ldo(14'd9, 5'd0, 5'd1), 32'h0, 32'h0, f_stw(14'd8, 5'd0, 5'd1)};
    restart();
    repeat (6) tick();
    chk("mid_gr1_pre", gr(1), 32'd9);
    reset = 1'b0;
    #1;
    chk("mid_pc_rst", dut.PCFrontOut, 32'd0);
    chk("mid_gr1_rst", gr(1), 32'd0);
    prog.delete();
    put_prog();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("mid_pc_restart", dut.PCFrontOut, 32'd4);
    chk("mid_store_abort", dword(8), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
